// File: rtl/imem_boot_loader_if.sv
// Bus bundle for imem_boot_loader: instruction fetch port plus byte-stream boot-load port.
//   master : the core / loader side (drives ADDR and LD_START/LD_VALID/LD_BYTE/LD_LAST)
//   slave  : the instruction memory (drives Q, MISALIGN, OOR, CPU_STALL, LD_READY,
//            LD_DONE, LD_COUNT)
// ADDR is a byte address; LD_COUNT is wide enough to hold DEPTH.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Q;
  logic              MISALIGN;
  logic              OOR;
  logic              CPU_STALL;
  logic              LD_START;
  logic              LD_VALID;
  logic [7:0]        LD_BYTE;
  logic              LD_LAST;
  logic              LD_READY;
  logic              LD_DONE;
  logic [CNT_W-1:0]  LD_COUNT;

  modport master (
    output ADDR, LD_START, LD_VALID, LD_BYTE, LD_LAST,
    input  Q, MISALIGN, OOR, CPU_STALL, LD_READY, LD_DONE, LD_COUNT
  );

  modport slave (
    input  ADDR, LD_START, LD_VALID, LD_BYTE, LD_LAST,
    output Q, MISALIGN, OOR, CPU_STALL, LD_READY, LD_DONE, LD_COUNT
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction memory for the 16-bit single-cycle core with a byte-stream boot loader.
// Fetch reads are combinational and byte-addressed (two bytes per word). A load is
// started with a LD_START pulse; bytes arrive high-byte-first over LD_VALID/LD_READY,
// are packed into words and written sequentially from word 0. The core is stalled
// until the load has finished.
// Ports:
//   CLK   : clock, all state updates on posedge
//   RESET : synchronous active-high reset; fills memory with FILL_WORD
//   bus   : imem_boot_loader_if.slave (fetch port + load port)
module imem_boot_loader #(
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DEPTH     = 128,
  parameter int unsigned       DATA_W    = 16,
  parameter logic [DATA_W-1:0] FILL_WORD = 16'h0000
) (
  input logic                CLK,
  input logic                RESET,
  imem_boot_loader_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StRun, StLoadHi, StLoadLo, StFinish} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        hi_q, hi_d;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              ready, stall, done;

  logic [DATA_W-1:0] mem [DEPTH];

  // Fetch path
  logic [ADDR_W-2:0] widx;
  logic              oor;

  assign widx         = bus.ADDR[ADDR_W-1:1];
  assign oor          = {1'b0, widx} >= ADDR_W'(DEPTH);
  assign bus.MISALIGN = bus.ADDR[0];
  assign bus.OOR      = oor;
  // Memory is only visible in RUN, so a same-cycle write and fetch never collide.
  assign bus.Q        = (state_q == StRun && !oor) ? mem[widx[IDX_W-1:0]] : FILL_WORD;

  assign bus.LD_READY  = ready;
  assign bus.CPU_STALL = stall;
  assign bus.LD_DONE   = done;
  assign bus.LD_COUNT  = cnt_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    we      = 1'b0;
    wdata   = '0;
    ready   = 1'b0;
    stall   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.LD_START) begin
          state_d = StLoadHi;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      StLoadHi: begin
        ready = 1'b1;
        stall = 1'b1;
        if (bus.LD_VALID) begin
          hi_d = bus.LD_BYTE;
          if (bus.LD_LAST) begin
            // Odd-length image: final word is padded with a zero low byte.
            we      = 1'b1;
            wdata   = {bus.LD_BYTE, 8'h00};
            cnt_d   = ptr_q + CNT_W'(1);
            state_d = StFinish;
          end else begin
            state_d = StLoadLo;
          end
        end
      end
      StLoadLo: begin
        ready = 1'b1;
        stall = 1'b1;
        if (bus.LD_VALID) begin
          we    = 1'b1;
          wdata = {hi_q, bus.LD_BYTE};
          cnt_d = ptr_q + CNT_W'(1);
          // Auto-finish once the last word slot is filled.
          if (bus.LD_LAST || ptr_q == CNT_W'(DEPTH - 1)) begin
            state_d = StFinish;
          end else begin
            ptr_d   = ptr_q + CNT_W'(1);
            state_d = StLoadHi;
          end
        end
      end
      StFinish: begin
        stall   = 1'b1;
        done    = 1'b1;
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StRun;
      ptr_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= FILL_WORD;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      if (we) begin
        mem[ptr_q[IDX_W-1:0]] <= wdata;
      end
    end
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Parametrised instruction memory for the 16-bit single-cycle core. It replaces a hard-wired reset-time program image with a byte-stream boot-load port. Instruction fetch reads are combinational and byte-addressed; each word occupies two consecutive byte addresses. A small FSM accepts program bytes over a valid/ready handshake, packs them into words, writes them sequentially from word 0, and holds the CPU stalled until the load completes.

Parameters:
ADDR_W, 8, byte-address width of the fetch port.
DEPTH, 128, number of instruction words. Must satisfy DEPTH <= 2^(ADDR_W-1).
DATA_W, 16, instruction word width. Fixed at 16; two bytes per word.
FILL_WORD, 16'h0000, value every entry takes on reset. Also returned for stalled or out-of-range fetches.

Ports:
CLK  input  1  clock; all state updates on posedge.
RESET  input  1  synchronous, active-high reset.
ADDR  input  ADDR_W  fetch byte address (PC).
Q  output  16  fetched instruction word.
MISALIGN  output  1  ADDR[0] set (fetch not word-aligned).
OOR  output  1  fetch word index ADDR[ADDR_W-1:1] >= DEPTH.
CPU_STALL  output  1  high while a load is in progress; core must not advance PC.
LD_START  input  1  single-cycle pulse that begins a program load.
LD_VALID  input  1  LD_BYTE is valid.
LD_BYTE  input  8  program byte; high byte of each word first.
LD_LAST  input  1  qualifies the final byte of the image.
LD_READY  output  1  block accepts LD_BYTE this cycle.
LD_DONE  output  1  one-cycle pulse when a load completes.
LD_COUNT  output  clog2(DEPTH+1)  number of words written by the most recent load.

Behaviour:
- Reset, on posedge with RESET=1:
  - all DEPTH entries <= FILL_WORD;
  - FSM <= RUN; word pointer, LD_COUNT and byte latch <= 0;
  - CPU_STALL=0, LD_READY=0, LD_DONE=0.
  - RESET overrides all other inputs, including mid-load; a partial image is discarded.
- Fetch path (combinational, zero latency):
  - widx = ADDR[ADDR_W-1:1]; MISALIGN = ADDR[0], informational only; the fetch still uses widx.
  - Q = mem[widx] when state==RUN and !OOR; otherwise Q = FILL_WORD.
- FSM states: RUN, LOAD_HI, LOAD_LO, FINISH.
  - RUN: LD_READY=0, CPU_STALL=0. On LD_START=1: go to LOAD_HI, pointer <= 0, LD_COUNT <= 0. Memory is not cleared; entries beyond the new image keep their old contents.
  - LOAD_HI: LD_READY=1, CPU_STALL=1.
    - On LD_VALID: latch byte as hi.
    - If LD_LAST=1 as well (odd-length image): write mem[ptr] <= {byte, 8'h00}, LD_COUNT <= ptr+1, go to FINISH.
    - Otherwise go to LOAD_LO.
  - LOAD_LO: LD_READY=1, CPU_STALL=1.
    - On LD_VALID: write mem[ptr] <= {hi, byte}, LD_COUNT <= ptr+1.
    - If LD_LAST=1 or ptr==DEPTH-1, go to FINISH. Otherwise ptr <= ptr+1 and go to LOAD_HI.
  - FINISH: LD_READY=0, CPU_STALL=1, LD_DONE=1 for exactly this cycle. Next state is RUN.
- Handshake:
  - A byte transfers only on posedge with LD_VALID && LD_READY.
  - No transfer occurs in the cycle LD_START is sampled (LD_READY is still 0).
  - LD_VALID may stay high across consecutive bytes, giving one byte per cycle.
- Capacity and start conditions:
  - Overflow: after word DEPTH-1 is written, the load auto-finishes.
  - Any bytes offered after that see LD_READY=0 and are not accepted.
  - LD_START outside RUN is ignored.
  - LD_LAST with LD_VALID=0 has no effect.
- Write/read ordering: a write and a fetch to the same word in the same cycle cannot conflict, because Q returns FILL_WORD while not in RUN.
- Load latency for N words: 2N transfer cycles + 1 FINISH cycle; CPU_STALL falls on the cycle after LD_DONE.

Test Plan:
- Reset then fetch ADDR=8'h00, 8'h10, 8'hFE (DEPTH=128) -> Q=16'h0000, OOR=0, CPU_STALL=0, LD_READY=0.
- Load bytes F0,01,51,7F,2A,79 back-to-back with LD_LAST on the 6th byte -> LD_DONE pulses one cycle after the 6th accept, LD_COUNT=3, and then:
  - ADDR=0 gives Q=F001;
  - ADDR=2 gives Q=517F;
  - ADDR=4 gives Q=2A79;
  - ADDR=6 gives Q=0000.
- Same load with LD_VALID toggling every other cycle, plus fetches during the load -> identical final contents; CPU_STALL=1 and Q=FILL_WORD throughout the load; no byte is accepted while LD_VALID=0.
- Odd image: bytes AB,CD,EF with LD_LAST on EF -> mem[1]=16'hEF00, LD_COUNT=2, LD_DONE pulses.
- Overflow with DEPTH=4 and 10 bytes streamed -> 8 bytes accepted, LD_READY drops, LD_COUNT=4, LD_DONE pulses; ADDR=8 gives OOR=1 and Q=FILL_WORD.
- RESET asserted after 3 bytes of a load -> state RUN, all words = FILL_WORD, LD_COUNT=0, CPU_STALL=0. Separately, ADDR=8'h03 after a load -> MISALIGN=1 and Q=mem[1].
